uart_tx_serializer: RTL and testbench

- UART transmit serializer.
- Latches a byte from the transmit holding register on a one-cycle enable pulse and shifts it out as an asynchronous serial frame: start bit, data LSB-first, optional parity, stop bit(s).
- Sits between the UART register file (THR, status) and the TX pad.
- Clocked directly by the bit-rate clock bclk; with default parameters one bclk cycle equals one bit time.

---
 rtl/uart_tx_serializer.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit serializer.
// Accepts a THR byte on a tx_en edge while idle and shifts out
// start bit, LSB-first data, optional parity and stop bit(s).
// Clocked by the bit-rate clock; every output is registered.
module uart_tx_serializer #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 bclk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] THR,
  input  logic                 tx_en,
  output logic                 tx_status,
  output logic                 tx_data
);

  // Cycle counter must hold STOP_BITS*CLKS_PER_BIT-1 (the longest state).
  localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int BIT_W = 3;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic             ODD_SEL   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam logic             PAR_USED  = (PARITY_EN != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    calc_parity = (^data) ^ odd;
  endfunction

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_clk_cnt, w_clk_cnt_nxt;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_parity, w_parity_nxt;
  logic                 r_tx_data, w_tx_data_nxt;
  logic                 r_tx_status, w_tx_status_nxt;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge bclk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_tx_data   <= 1'b1;
      r_tx_status <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_clk_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_parity    <= w_parity_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_status <= w_tx_status_nxt;
    end
  end

  // Next-state logic; outputs are computed for the state being entered
  // so the line level changes on the same edge as the state.
  always_comb begin
    w_state_nxt     = r_state;
    w_clk_cnt_nxt   = r_clk_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_parity_nxt    = r_parity;
    w_tx_data_nxt   = r_tx_data;
    w_tx_status_nxt = r_tx_status;
    case (r_state)
      IDLE: begin
        w_tx_data_nxt   = 1'b1;
        w_tx_status_nxt = 1'b0;
        if (tx_en) begin
          w_shift_nxt     = THR;
          w_parity_nxt    = calc_parity(THR, ODD_SEL);
          w_clk_cnt_nxt   = '0;
          w_bit_cnt_nxt   = '0;
          w_state_nxt     = START;
          w_tx_data_nxt   = 1'b0;
          w_tx_status_nxt = 1'b1;
        end else begin
          w_clk_cnt_nxt = '0;
        end
      end
      START: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = DATA;
          w_tx_data_nxt = r_shift[0];
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_nxt = '0;
          if (r_bit_cnt == DATA_LAST) begin
            if (PAR_USED) begin
              w_state_nxt   = PARITY;
              w_tx_data_nxt = r_parity;
            end else begin
              w_state_nxt   = STOP;
              w_tx_data_nxt = 1'b1;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
            w_shift_nxt   = r_shift >> 1;
            w_tx_data_nxt = r_shift[1];
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_nxt = '0;
          w_state_nxt   = STOP;
          w_tx_data_nxt = 1'b1;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        w_tx_data_nxt = 1'b1;
        if (r_clk_cnt == STOP_LAST) begin
          w_clk_cnt_nxt   = '0;
          w_state_nxt     = IDLE;
          w_tx_status_nxt = 1'b0;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_clk_cnt_nxt   = '0;
        w_bit_cnt_nxt   = '0;
        w_tx_data_nxt   = 1'b1;
        w_tx_status_nxt = 1'b0;
      end
    endcase
  end

  assign tx_data   = r_tx_data;
  assign tx_status = r_tx_status;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed testbench for uart_tx_serializer: default-parameter instance
// plus an instance with even parity, two stop bits and 4 clocks per bit.
module tb_uart_tx_serializer;

  logic       bclk;
  logic       rst;
  logic [7:0] thr;
  logic       tx_en;
  logic       tx_status;
  logic       tx_data;
  logic [7:0] thr_p;
  logic       tx_en_p;
  logic       tx_status_p;
  logic       tx_data_p;

  int checks;
  int failures;

  uart_tx_serializer dut (
    .bclk      (bclk),
    .rst       (rst),
    .THR       (thr),
    .tx_en     (tx_en),
    .tx_status (tx_status),
    .tx_data   (tx_data)
  );

  uart_tx_serializer #(
    .DATA_BITS    (8),
    .CLKS_PER_BIT (4),
    .PARITY_EN    (1),
    .PARITY_ODD   (0),
    .STOP_BITS    (2)
  ) dut_p (
    .bclk      (bclk),
    .rst       (rst),
    .THR       (thr_p),
    .tx_en     (tx_en_p),
    .tx_status (tx_status_p),
    .tx_data   (tx_data_p)
  );

  // Free-running bit clock.
  initial begin
    bclk = 1'b0;
    forever #5 bclk = ~bclk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse tx_en, then compare the 10 frame cycles against seq (bit i = cycle i).
  // hold_en keeps tx_en high; poke_cycle re-pulses tx_en mid-frame; thr_flip changes THR mid-frame.
  task automatic run_frame(input string tag, input logic [7:0] byte_v, input logic [9:0] seq,
                           input bit hold_en, input int poke_cycle, input bit thr_flip);
    thr   = byte_v;
    tx_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge bclk);
      check_val({tag, "_data"}, {31'd0, tx_data}, {31'd0, seq[i]});
      check_val({tag, "_busy"}, {31'd0, tx_status}, 32'd1);
      if (!hold_en) tx_en = (i + 1 == poke_cycle) ? 1'b1 : 1'b0;
      if (thr_flip && i == 3) thr = 8'hFF;
    end
    @(negedge bclk);
    check_val({tag, "_end_busy"}, {31'd0, tx_status}, 32'd0);
    check_val({tag, "_end_data"}, {31'd0, tx_data}, 32'd1);
  endtask

  initial begin
    logic [11:0] seq_p;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    tx_en    = 1'b0;
    thr      = 8'h00;
    tx_en_p  = 1'b0;
    thr_p    = 8'h00;

    // 1. Reset held two cycles, then 20 idle cycles.
    for (int i = 0; i < 2; i++) begin
      @(negedge bclk);
      check_val("rst_data", {31'd0, tx_data}, 32'd1);
      check_val("rst_busy", {31'd0, tx_status}, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge bclk);
      check_val("idle_data", {31'd0, tx_data}, 32'd1);
      check_val("idle_busy", {31'd0, tx_status}, 32'd0);
    end

    // 2. 0x6C frame: 0,0,0,1,1,0,1,1,0,1.
    run_frame("f6c", 8'h6C, 10'b1011011000, 1'b0, -1, 1'b0);
    repeat (2) @(negedge bclk);

    // 3. 0x6D frame with THR flipped to 0xFF mid-frame: 0,1,0,1,1,0,1,1,0,1.
    run_frame("f6d", 8'h6D, 10'b1011011010, 1'b0, -1, 1'b1);
    repeat (2) @(negedge bclk);

    // 4. tx_en re-pulsed on cycle 4 of a frame is ignored.
    run_frame("poke", 8'h6C, 10'b1011011000, 1'b0, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge bclk);
      check_val("poke_idle_busy", {31'd0, tx_status}, 32'd0);
      check_val("poke_idle_data", {31'd0, tx_data}, 32'd1);
    end

    // 5. Reset at cycle 5 of a frame aborts it; reset also beats tx_en.
    thr   = 8'h6C;
    tx_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge bclk);
      tx_en = 1'b0;
    end
    check_val("pre_abort_busy", {31'd0, tx_status}, 32'd1);
    rst   = 1'b1;
    tx_en = 1'b1;
    @(negedge bclk);
    check_val("abort_data", {31'd0, tx_data}, 32'd1);
    check_val("abort_busy", {31'd0, tx_status}, 32'd0);
    rst   = 1'b0;
    tx_en = 1'b0;
    @(negedge bclk);
    check_val("post_abort_busy", {31'd0, tx_status}, 32'd0);
    run_frame("clean", 8'h6C, 10'b1011011000, 1'b0, -1, 1'b0);

    // tx_en held: back-to-back frames restart from the first idle edge.
    run_frame("held1", 8'h6D, 10'b1011011010, 1'b1, -1, 1'b0);
    @(negedge bclk);
    check_val("held2_start_data", {31'd0, tx_data}, 32'd0);
    check_val("held2_start_busy", {31'd0, tx_status}, 32'd1);
    tx_en = 1'b0;
    repeat (12) @(negedge bclk);
    check_val("held2_done_busy", {31'd0, tx_status}, 32'd0);

    // 6. Parity instance, 0x6C: start, data, parity 0, two stops, 4 clocks each.
    seq_p   = 12'b110011011000;
    thr_p   = 8'h6C;
    tx_en_p = 1'b1;
    for (int k = 0; k < 48; k++) begin
      @(negedge bclk);
      tx_en_p = 1'b0;
      thr_p   = 8'h00;
      check_val("par_data", {31'd0, tx_data_p}, {31'd0, seq_p[k / 4]});
      check_val("par_busy", {31'd0, tx_status_p}, 32'd1);
    end
    @(negedge bclk);
    check_val("par_end_busy", {31'd0, tx_status_p}, 32'd0);
    check_val("par_end_data", {31'd0, tx_data_p}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
